// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes common with
// alu_control_unit and the execute FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter. Direction and fill mode are captured on load;
// done flags the cycle whose clock edge performs the final shift.
module alu_serial_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SHW-1:0]   amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_left,
    input  logic             arith,
    output logic [WIDTH-1:0] next_data,
    output logic             done
);

    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   count;
    logic             left_q;
    logic             arith_q;
    logic             fill;

    assign fill = arith_q & data[WIDTH-1];

    always_comb begin
        next_data = data;
        if (left_q) begin
            next_data = {data[WIDTH-2:0], 1'b0};
        end else begin
            next_data = {fill, data[WIDTH-1:1]};
        end
    end

    // The owner registers next_data on the same edge the count reaches zero.
    assign done = (count == SHW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            count   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            data    <= data_in;
            count   <= amount;
            left_q  <= shift_left;
            arith_q <= arith;
        end else if (count != '0) begin
            data  <= next_data;
            count <= count - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute stage: single-cycle logic/arithmetic, serial shifts, and a
// registered result with zero and illegal flags behind valid/ready handshakes.
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; requests are taken only in IDLE and results are held in DONE.
    alu_state_e       state;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_y;
    logic             op_illegal;
    logic             op_shift;
    logic [SHW-1:0]   shamt;
    logic             shift_load;
    logic [WIDTH-1:0] sh_next;
    logic             sh_done;

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_y      = '0;
        op_illegal = 1'b0;
        op_shift   = 1'b0;
        case (alu_op)
            ALU_AND: alu_y = op_a & op_b;
            ALU_OR:  alu_y = op_a | op_b;
            ALU_ADD: alu_y = op_a + op_b;
            ALU_SUB: alu_y = op_a - op_b;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_XOR: alu_y = op_a ^ op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                // A zero-amount shift completes directly with op_a.
                op_shift = 1'b1;
                alu_y    = op_a;
            end
            default: op_illegal = 1'b1;
        endcase
    end

    assign shift_load = (state == IDLE) && in_valid && op_shift && (shamt != '0);

    alu_serial_shifter #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (shift_load),
        .amount    (shamt),
        .data_in   (op_a),
        .shift_left(alu_op == ALU_SLL),
        .arith     (alu_op == ALU_SRA),
        .next_data (sh_next),
        .done      (sh_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        illegal_q <= op_illegal;
                        if (shift_load) begin
                            state <= SHIFT;
                        end else begin
                            result_q <= alu_y;
                            zero_q   <= (alu_y == '0);
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        result_q <= sh_next;
                        zero_q   <= (sh_next == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready also drops during reset so nothing is offered while it is held.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
